// File: rtl/disact_mc.sv
// disact_mc: multi-lane activation dispatcher.
// Reads one block header (flag + count), fetches ceil(count/NUM_LANE) packed
// data words, scatters the packed values onto the flagged positions and holds
// the resulting dense block until the consumer takes it.
module disact_mc #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_DEPTH = 32,
  parameter int NUM_LANE    = 4,
  parameter int ADDR_WIDTH  = 12,
  parameter int ACT_WORDS   = 4096,
  parameter int HDR_WORDS   = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fetch,
  input  logic                              clr_addr,
  output logic                              act_rdy,
  input  logic                              act_get,
  output logic                              ctrl_get,
  output logic [BLOCK_DEPTH-1:0]            act_flg,
  output logic [DATA_WIDTH*BLOCK_DEPTH-1:0] act_dat,
  output logic                              err_cnt,
  input  logic                              gbfact_val,
  input  logic                              gbfflg_val,
  input  logic                              gbfvn_val,
  output logic                              gbfact_en,
  output logic [ADDR_WIDTH-1:0]             gbfact_addr,
  input  logic [DATA_WIDTH*NUM_LANE-1:0]    gbfact_dat,
  output logic                              gbfflg_en,
  output logic [ADDR_WIDTH-1:0]             gbfflg_addr,
  input  logic [BLOCK_DEPTH-1:0]            gbfflg_dat,
  output logic                              gbfvn_en,
  output logic [ADDR_WIDTH-1:0]             gbfvn_addr,
  input  logic [$clog2(BLOCK_DEPTH):0]      gbfvn_dat
);

  localparam int CW = $clog2(BLOCK_DEPTH) + 1;
  localparam int LW = NUM_LANE * DATA_WIDTH;
  localparam int PW = BLOCK_DEPTH * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ACT_LAST = ADDR_WIDTH'(ACT_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] HDR_LAST = ADDR_WIDTH'(HDR_WORDS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLOCK_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_HEAD   = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_FILL   = 3'd4;
  localparam logic [2:0] S_EXPAND = 3'd5;
  localparam logic [2:0] S_WAIT   = 3'd6;

  logic [2:0]            r_state;
  logic [BLOCK_DEPTH-1:0] r_flg;
  logic [CW-1:0]         r_cnt;
  logic                  r_ovf;
  logic [CW-1:0]         r_words;
  logic [CW-1:0]         r_ld_cnt;
  logic                  r_rd_pend;
  logic [CW-1:0]         r_cap_idx;
  logic [PW-1:0]         r_pack;
  logic [PW-1:0]         r_act_dat;
  logic [BLOCK_DEPTH-1:0] r_act_flg;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_hdr_addr;
  logic [ADDR_WIDTH-1:0] r_act_addr;

  logic                  w_hdr_go;
  logic                  w_act_en;
  logic [CW-1:0]         w_cnt_sat;
  logic                  w_cnt_ovf;
  logic [CW-1:0]         w_words;
  logic [CW-1:0]         w_rank [BLOCK_DEPTH];
  logic [CW-1:0]         w_pop;
  logic [PW-1:0]         w_dense;

  assign w_hdr_go  = (r_state == S_CHECK) && gbfact_val && gbfflg_val && gbfvn_val;
  assign w_act_en  = (r_state == S_LOAD);
  // A count beyond the block size is clamped; the overflow is reported as an error.
  assign w_cnt_ovf = (gbfvn_dat > CNT_MAX);
  assign w_cnt_sat = w_cnt_ovf ? CNT_MAX : gbfvn_dat;
  assign w_words   = CW'((int'(w_cnt_sat) + NUM_LANE - 1) / NUM_LANE);

  assign act_rdy     = (r_state == S_WAIT);
  assign ctrl_get    = act_get && act_rdy;
  assign act_dat     = r_act_dat;
  assign act_flg     = r_act_flg;
  assign err_cnt     = r_err;
  assign gbfact_en   = w_act_en;
  assign gbfact_addr = r_act_addr;
  assign gbfflg_en   = w_hdr_go;
  assign gbfvn_en    = w_hdr_go;
  assign gbfflg_addr = r_hdr_addr;
  assign gbfvn_addr  = r_hdr_addr;

  // Rank of each position = number of set flag bits below it; the final sum is the popcount.
  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < BLOCK_DEPTH; i++) begin
      w_rank[i] = acc;
      acc = acc + CW'(r_flg[i]);
    end
    w_pop = acc;
  end

  // Scatter: a flagged position takes the packed value of its rank, if that value exists.
  for (genvar gi = 0; gi < BLOCK_DEPTH; gi++) begin : g_pos
    assign w_dense[gi*DATA_WIDTH +: DATA_WIDTH] =
      (r_flg[gi] && (w_rank[gi] < r_cnt)) ? r_pack[int'(w_rank[gi])*DATA_WIDTH +: DATA_WIDTH]
                                          : '0;
  end

  // Block sequencing FSM plus header capture and held output block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_flg     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_words   <= '0;
      r_ld_cnt  <= '0;
      r_act_dat <= '0;
      r_act_flg <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!clr_addr && fetch) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_hdr_go) r_state <= S_HEAD;
        end
        S_HEAD: begin
          r_flg    <= gbfflg_dat;
          r_cnt    <= w_cnt_sat;
          r_ovf    <= w_cnt_ovf;
          r_words  <= w_words;
          r_ld_cnt <= '0;
          r_state  <= (w_words == '0) ? S_EXPAND : S_LOAD;
        end
        S_LOAD: begin
          r_ld_cnt <= r_ld_cnt + CW'(1);
          if (r_ld_cnt == r_words - CW'(1)) r_state <= S_FILL;
        end
        S_FILL: begin
          r_state <= S_EXPAND;
        end
        S_EXPAND: begin
          r_act_dat <= w_dense;
          r_act_flg <= r_flg;
          if (r_ovf || (w_pop != r_cnt)) r_err <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (act_get) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Append each returned data word to the packed register, one slot per word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_cap_idx <= '0;
      r_pack    <= '0;
    end else begin
      r_rd_pend <= w_act_en;
      if (r_state == S_HEAD) begin
        r_cap_idx <= '0;
      end else if (r_rd_pend) begin
        r_pack[int'(r_cap_idx)*LW +: LW] <= gbfact_dat;
        r_cap_idx <= r_cap_idx + CW'(1);
      end
    end
  end

  // Read address counters; data words are packed back to back, so no per-block realignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hdr_addr <= '0;
      r_act_addr <= '0;
    end else if ((r_state == S_IDLE) && clr_addr) begin
      r_hdr_addr <= '0;
      r_act_addr <= '0;
    end else begin
      if (w_hdr_go) r_hdr_addr <= (r_hdr_addr == HDR_LAST) ? '0 : r_hdr_addr + ADDR_WIDTH'(1);
      if (w_act_en) r_act_addr <= (r_act_addr == ACT_LAST) ? '0 : r_act_addr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_disact_mc.sv
// Directed testbench for disact_mc with small buffer models and per-scenario checks.
module tb_disact_mc;

  localparam int DW = 8;
  localparam int BD = 32;
  localparam int NL = 4;
  localparam int AW = 12;
  localparam int AWORDS = 8;
  localparam int HWORDS = 16;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst, fetch, clr_addr, act_get;
  logic act_rdy, ctrl_get, err_cnt;
  logic [BD-1:0] act_flg;
  logic [DW*BD-1:0] act_dat;
  logic gbfact_val, gbfflg_val, gbfvn_val;
  logic gbfact_en, gbfflg_en, gbfvn_en;
  logic [AW-1:0] gbfact_addr, gbfflg_addr, gbfvn_addr;
  logic [DW*NL-1:0] gbfact_dat;
  logic [BD-1:0] gbfflg_dat;
  logic [CW-1:0] gbfvn_dat;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_hdr_en = 0;
  int rd_q[$];

  logic [DW*NL-1:0] act_mem [AWORDS];
  logic [BD-1:0]    flg_mem [HWORDS];
  logic [CW-1:0]    vn_mem  [HWORDS];

  disact_mc #(
    .DATA_WIDTH(DW), .BLOCK_DEPTH(BD), .NUM_LANE(NL), .ADDR_WIDTH(AW),
    .ACT_WORDS(AWORDS), .HDR_WORDS(HWORDS)
  ) dut (
    .clk(clk), .rst(rst), .fetch(fetch), .clr_addr(clr_addr),
    .act_rdy(act_rdy), .act_get(act_get), .ctrl_get(ctrl_get),
    .act_flg(act_flg), .act_dat(act_dat), .err_cnt(err_cnt),
    .gbfact_val(gbfact_val), .gbfflg_val(gbfflg_val), .gbfvn_val(gbfvn_val),
    .gbfact_en(gbfact_en), .gbfact_addr(gbfact_addr), .gbfact_dat(gbfact_dat),
    .gbfflg_en(gbfflg_en), .gbfflg_addr(gbfflg_addr), .gbfflg_dat(gbfflg_dat),
    .gbfvn_en(gbfvn_en), .gbfvn_addr(gbfvn_addr), .gbfvn_dat(gbfvn_dat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer models: one-cycle registered read.
  always @(posedge clk) begin
    if (gbfact_en) gbfact_dat <= act_mem[gbfact_addr[2:0]];
    if (gbfflg_en) gbfflg_dat <= flg_mem[gbfflg_addr[3:0]];
    if (gbfvn_en)  gbfvn_dat  <= vn_mem[gbfvn_addr[3:0]];
  end

  // Record data-read addresses and header-read count.
  always @(negedge clk) begin
    if (gbfact_en) rd_q.push_back(int'(gbfact_addr));
    if (gbfflg_en) n_hdr_en <= n_hdr_en + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Fetch a block and return cycles from fetch to first act_rdy (-1 on timeout).
  task automatic run_block(input int refetch, output int lat);
    int t0;
    rd_q.delete();
    lat = -1;
    t0 = cyc;
    fetch = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      if (act_rdy === 1'b1) begin
        lat = cyc - t0;
        break;
      end
      fetch = ((cyc - t0) == refetch) ? 1'b1 : 1'b0;
    end
    fetch = 1'b0;
  endtask

  task automatic release_block();
    act_get = 1'b1;
    @(posedge clk); #1;
    act_get = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_vec++; if (act_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b want 0", act_rdy); end
    n_vec++; if ({gbfact_en, gbfflg_en, gbfvn_en} !== 3'b000) begin n_err++; $display("FAIL reset_strobes: got %b want 000", {gbfact_en, gbfflg_en, gbfvn_en}); end
    n_vec++; if ({gbfact_addr, gbfflg_addr, gbfvn_addr} !== '0) begin n_err++; $display("FAIL reset_addr: got %h %h %h want 0", gbfact_addr, gbfflg_addr, gbfvn_addr); end
    n_vec++; if (act_dat !== '0 || act_flg !== '0) begin n_err++; $display("FAIL reset_out: dat %h flg %h want 0", act_dat, act_flg); end
    n_vec++; if (err_cnt !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_dense();
    logic [DW*BD-1:0] exp;
    int lat;
    bit ok;
    flg_mem[0] = 32'hFFFF_FFFF; vn_mem[0] = 6'd32;
    for (int k = 0; k < 8; k++)
      for (int l = 0; l < NL; l++) act_mem[k][l*DW +: DW] = 8'(4*k + l + 1);
    for (int i = 0; i < BD; i++) exp[i*DW +: DW] = 8'(i + 1);
    run_block(0, lat);
    n_vec++; if (lat != 13) begin n_err++; $display("FAIL dense_latency: got %0d want 13", lat); end
    ok = (rd_q.size() == 8);
    for (int k = 0; k < rd_q.size(); k++) if (rd_q[k] != k) ok = 0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL dense_reads: got %0d reads, want 8 at 0..7", rd_q.size()); end
    n_vec++; if (act_dat !== exp) begin n_err++; $display("FAIL dense_dat: got %h want %h", act_dat, exp); end
    n_vec++; if (act_flg !== 32'hFFFF_FFFF || err_cnt !== 1'b0) begin n_err++; $display("FAIL dense_flg_err: flg %h err %b want ffffffff 0", act_flg, err_cnt); end
    release_block();
    n_vec++; if (act_rdy !== 1'b0 || gbfact_addr !== 12'd0 || gbfflg_addr !== 12'd1) begin n_err++; $display("FAIL dense_after: rdy %b aaddr %0d haddr %0d want 0 0 1", act_rdy, gbfact_addr, gbfflg_addr); end
  endtask

  task automatic test_sparse();
    logic [DW*BD-1:0] exp;
    int lat;
    flg_mem[1] = 32'h8000_0005; vn_mem[1] = 6'd3;
    act_mem[0] = {8'hFF, 8'h0C, 8'h0B, 8'h0A};
    exp = '0;
    exp[7:0] = 8'h0A; exp[23:16] = 8'h0B; exp[255:248] = 8'h0C;
    run_block(0, lat);
    n_vec++; if (lat != 6) begin n_err++; $display("FAIL sparse_latency: got %0d want 6", lat); end
    n_vec++; if (rd_q.size() != 1 || rd_q[0] != 0) begin n_err++; $display("FAIL sparse_reads: got %0d reads want 1 at 0", rd_q.size()); end
    n_vec++; if (act_dat !== exp) begin n_err++; $display("FAIL sparse_dat: got %h want %h", act_dat, exp); end
    release_block();
    n_vec++; if (gbfact_addr !== 12'd1) begin n_err++; $display("FAIL sparse_next_addr: got %0d want 1", gbfact_addr); end
  endtask

  task automatic test_bypass();
    int lat;
    flg_mem[2] = '0; vn_mem[2] = '0;
    run_block(0, lat);
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL bypass_latency: got %0d want 4", lat); end
    n_vec++; if (rd_q.size() != 0) begin n_err++; $display("FAIL bypass_reads: got %0d want 0", rd_q.size()); end
    n_vec++; if (act_dat !== '0 || act_flg !== '0) begin n_err++; $display("FAIL bypass_dat: dat %h flg %h want 0", act_dat, act_flg); end
    release_block();
    n_vec++; if (gbfflg_addr !== 12'd3 || gbfact_addr !== 12'd1) begin n_err++; $display("FAIL bypass_addr: haddr %0d aaddr %0d want 3 1", gbfflg_addr, gbfact_addr); end
  endtask

  task automatic test_handshake();
    logic [DW*BD-1:0] exp;
    int lat, h0, bad;
    flg_mem[3] = 32'h000F_FFFF; vn_mem[3] = 6'd20;
    for (int k = 0; k < 5; k++)
      for (int l = 0; l < NL; l++) act_mem[1+k][l*DW +: DW] = 8'(8'h20 + 4*k + l);
    exp = '0;
    for (int j = 0; j < 20; j++) exp[j*DW +: DW] = 8'(8'h20 + j);
    h0 = n_hdr_en;
    run_block(4, lat);
    n_vec++; if (lat != 10) begin n_err++; $display("FAIL hs_latency: got %0d want 10", lat); end
    n_vec++; if (act_dat !== exp) begin n_err++; $display("FAIL hs_dat: got %h want %h", act_dat, exp); end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (act_rdy !== 1'b1 || act_dat !== exp) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL hs_hold: %0d unstable cycles want 0", bad); end
    act_get = 1'b1; #1;
    n_vec++; if (ctrl_get !== 1'b1) begin n_err++; $display("FAIL hs_ctrl_get: got %b want 1", ctrl_get); end
    @(posedge clk); #1;
    act_get = 1'b0;
    n_vec++; if (act_rdy !== 1'b0) begin n_err++; $display("FAIL hs_release: rdy %b want 0", act_rdy); end
    repeat (3) @(posedge clk); #1;
    n_vec++; if (n_hdr_en - h0 != 1) begin n_err++; $display("FAIL hs_refetch_dropped: header reads %0d want 1", n_hdr_en - h0); end
    n_vec++; if (gbfact_addr !== 12'd6) begin n_err++; $display("FAIL hs_next_addr: got %0d want 6", gbfact_addr); end
  endtask

  task automatic test_wrap();
    logic [DW*BD-1:0] exp;
    int lat;
    bit ok;
    int want[4] = '{6, 7, 0, 1};
    flg_mem[4] = 32'h0000_FFFF; vn_mem[4] = 6'd16;
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < NL; l++) act_mem[(6+k)%8][l*DW +: DW] = 8'(8'h40 + 4*k + l);
    exp = '0;
    for (int j = 0; j < 16; j++) exp[j*DW +: DW] = 8'(8'h40 + j);
    run_block(0, lat);
    act_get = 1'b1;
    n_vec++; if (lat != 9) begin n_err++; $display("FAIL wrap_latency: got %0d want 9", lat); end
    ok = (rd_q.size() == 4);
    for (int k = 0; k < rd_q.size() && k < 4; k++) if (rd_q[k] != want[k]) ok = 0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_reads: got %0d reads, want 6 7 0 1", rd_q.size()); end
    n_vec++; if (act_dat !== exp) begin n_err++; $display("FAIL wrap_dat: got %h want %h", act_dat, exp); end
    @(posedge clk); #1;
    act_get = 1'b0;
    n_vec++; if (act_rdy !== 1'b0 || gbfact_addr !== 12'd2) begin n_err++; $display("FAIL wrap_after: rdy %b aaddr %0d want 0 2", act_rdy, gbfact_addr); end
  endtask

  // Called straight after test_wrap, so its fetch lands in the first IDLE cycle.
  task automatic test_back_to_back_mismatch();
    logic [DW*BD-1:0] exp;
    int lat;
    flg_mem[5] = 32'h0000_0003; vn_mem[5] = 6'd1;
    act_mem[2] = {8'hEE, 8'hDD, 8'h77, 8'h5A};
    exp = '0; exp[7:0] = 8'h5A;
    run_block(0, lat);
    n_vec++; if (lat != 6) begin n_err++; $display("FAIL b2b_latency: got %0d want 6", lat); end
    n_vec++; if (act_dat !== exp || act_flg !== 32'h3) begin n_err++; $display("FAIL mismatch_dat: dat %h flg %h want %h 3", act_dat, act_flg, exp); end
    n_vec++; if (err_cnt !== 1'b1) begin n_err++; $display("FAIL mismatch_err: got %b want 1", err_cnt); end
    release_block();
    flg_mem[6] = 32'h0000_0001; vn_mem[6] = 6'd1;
    act_mem[3] = {8'h99, 8'h88, 8'h22, 8'h11};
    exp = '0; exp[7:0] = 8'h11;
    run_block(0, lat);
    n_vec++; if (lat != 6 || act_dat !== exp) begin n_err++; $display("FAIL good_after_err: lat %0d dat %h want 6 %h", lat, act_dat, exp); end
    n_vec++; if (err_cnt !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err_cnt); end
    release_block();
  endtask

  task automatic test_clr_addr();
    int h0;
    h0 = n_hdr_en;
    clr_addr = 1'b1; fetch = 1'b1;
    @(posedge clk); #1;
    clr_addr = 1'b0; fetch = 1'b0;
    n_vec++; if ({gbfact_addr, gbfflg_addr, gbfvn_addr} !== '0) begin n_err++; $display("FAIL clr_addr: got %0d %0d %0d want 0", gbfact_addr, gbfflg_addr, gbfvn_addr); end
    n_vec++; if (gbfflg_en !== 1'b0) begin n_err++; $display("FAIL clr_no_fetch: hdr strobe %b want 0", gbfflg_en); end
    repeat (3) @(posedge clk); #1;
    n_vec++; if (n_hdr_en != h0 || act_rdy !== 1'b0) begin n_err++; $display("FAIL clr_idle: hdr reads %0d rdy %b want 0 0", n_hdr_en - h0, act_rdy); end
  endtask

  task automatic test_rst_in_load();
    bit seen;
    flg_mem[0] = 32'h0000_00FF; vn_mem[0] = 6'd8;
    act_mem[0] = 32'h0403_0201; act_mem[1] = 32'h0807_0605;
    fetch = 1'b1;
    @(posedge clk); #1;
    fetch = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (gbfact_en === 1'b1) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL rst_load_reach: no data strobe within 20 cycles"); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if ({gbfact_en, gbfflg_en, gbfvn_en} !== 3'b000 || act_rdy !== 1'b0) begin n_err++; $display("FAIL rst_strobes: got %b rdy %b want 000 0", {gbfact_en, gbfflg_en, gbfvn_en}, act_rdy); end
    n_vec++; if ({gbfact_addr, gbfflg_addr, gbfvn_addr} !== '0) begin n_err++; $display("FAIL rst_addr: got %0d %0d %0d want 0", gbfact_addr, gbfflg_addr, gbfvn_addr); end
    n_vec++; if (act_dat !== '0 || act_flg !== '0 || err_cnt !== 1'b0) begin n_err++; $display("FAIL rst_out: dat %h flg %h err %b want 0", act_dat, act_flg, err_cnt); end
    @(posedge clk); #1;
    n_vec++; if (gbfact_en !== 1'b0 || gbfflg_en !== 1'b0) begin n_err++; $display("FAIL rst_idle: act_en %b hdr_en %b want 0 0", gbfact_en, gbfflg_en); end
  endtask

  initial begin
    rst = 1'b1; fetch = 1'b0; clr_addr = 1'b0; act_get = 1'b0;
    gbfact_val = 1'b1; gbfflg_val = 1'b1; gbfvn_val = 1'b1;
    gbfact_dat = '0; gbfflg_dat = '0; gbfvn_dat = '0;
    for (int i = 0; i < AWORDS; i++) act_mem[i] = '0;
    for (int i = 0; i < HWORDS; i++) begin flg_mem[i] = '0; vn_mem[i] = '0; end
    test_reset();
    test_dense();
    test_sparse();
    test_bypass();
    test_handshake();
    test_wrap();
    test_back_to_back_mismatch();
    test_clr_addr();
    test_rst_in_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
